// File: rtl/aes_out_serializer.sv
// AES ciphertext serializer: DEPTH-entry 128-bit FIFO drained MSB-first as bytes; first byte 1 cycle after accept, held under dout_ready=0.
// Blocks arriving with no free slot are dropped and latch overflow; define AES_OUT_PARITY_EN to add the dout_par output.
module aes_out_serializer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] C_in,
  input  logic         valid_in,
  output logic [7:0]   dout,
  output logic         dout_valid,
  input  logic         dout_ready,
`ifdef AES_OUT_PARITY_EN
  output logic         dout_par,
`endif
  output logic         full,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic [127:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, wr_ptr_nxt;
  logic [AW-1:0]   rd_ptr, rd_ptr_nxt;
  logic [AW:0]     count, count_nxt;
  logic [3:0]      byte_cnt, byte_cnt_nxt;
  logic            full_q, overflow_q, overflow_nxt;
  logic            xfer, pop, slot_free, wr_en, drop;
  logic [127:0]    head;
  logic [6:0]      sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      byte_cnt   <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      byte_cnt   <= byte_cnt_nxt;
      full_q     <= (count_nxt == FULL_CNT);
      overflow_q <= overflow_nxt;
    end
  end

  // Storage deliberately has no reset; stale contents are never presented.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= C_in;
    end
  end

  always_comb begin
    xfer         = 1'b0;
    pop          = 1'b0;
    slot_free    = 1'b0;
    wr_en        = 1'b0;
    drop         = 1'b0;
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    byte_cnt_nxt = byte_cnt;
    overflow_nxt = overflow_q;

    xfer      = (state == SEND) && dout_ready;
    pop       = xfer && (byte_cnt == 4'd15);
    // A full FIFO still takes a block when the head's last byte leaves this cycle.
    slot_free = (count < FULL_CNT) || pop;
    wr_en     = valid_in && slot_free;
    drop      = valid_in && !slot_free;

    if (xfer) begin
      byte_cnt_nxt = byte_cnt + 4'd1;
    end
    if (pop) begin
      rd_ptr_nxt = rd_ptr + AW'(1);
    end
    if (wr_en) begin
      wr_ptr_nxt = wr_ptr + AW'(1);
    end
    if (drop) begin
      overflow_nxt = 1'b1;
    end

    case ({wr_en, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase

    case (state)
      IDLE: begin
        if (wr_en) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (pop && (count == CNT_ONE) && !wr_en) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte b of the head sits at bit 8*(15-b); for a 4-bit b, 15-b is ~b.
  assign head       = mem[rd_ptr];
  assign sel        = {~byte_cnt, 3'b000};
  assign dout_valid = (state == SEND);
  assign dout       = dout_valid ? head[sel +: 8] : 8'h00;
  assign full       = full_q;
  assign overflow   = overflow_q;

`ifdef AES_OUT_PARITY_EN
  assign dout_par = ^dout;
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer (DEPTH=4): single block, backpressure, overflow, write-at-full, reset mid-transfer.
module tb_aes_out_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] C_in;
  logic         valid_in;
  logic [7:0]   dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         full;
  logic         overflow;
`ifdef AES_OUT_PARITY_EN
  logic         dout_par;
`endif

  int checks = 0;
  int passes = 0;

  localparam logic [127:0] BLK0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [7:0] exp0 [16] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                            8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};

  always #5 clk = ~clk;

  aes_out_serializer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .C_in       (C_in),
    .valid_in   (valid_in),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
`ifdef AES_OUT_PARITY_EN
    .dout_par   (dout_par),
`endif
    .full       (full),
    .overflow   (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Block k carries byte value k*16+b at byte position b (MSB first).
  function automatic logic [127:0] mk_blk(input int k);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = 8'(k*16 + b);
    return r;
  endfunction

  initial begin
    logic [7:0] got [16];
    logic [7:0] held_val;
    logic       held;
    int         n;
    int         order [4];

    rst = 1'b0; valid_in = 1'b0; dout_ready = 1'b0; C_in = '0;
    #2;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
`ifdef AES_OUT_PARITY_EN
    chk("rst_par", dout_par, 0);
`endif
    step(); step();
    rst = 1'b1; dout_ready = 1'b1;
    step(); step();
    chk("idle_ignores_ready", dout_valid, 0);

    // Single block, consumer always ready
    C_in = BLK0; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("t1_latency", dout_valid, 1);
    for (int b = 0; b < 16; b++) begin
      chk("t1_byte", dout, exp0[b]);
`ifdef AES_OUT_PARITY_EN
      if (b == 0) chk("par_69", dout_par, 0);
      if (b == 1) chk("par_c4", dout_par, 1);
`endif
      step();
    end
    chk("t1_idle", dout_valid, 0);
    chk("t1_full", full, 0);

    // Backpressure: ready toggles 1,0,1,0
    C_in = BLK0; valid_in = 1'b1; dout_ready = 1'b0;
    step();
    valid_in = 1'b0;
    n = 0; held = 1'b0; held_val = 8'h00;
    for (int c = 0; c < 64 && n < 16; c++) begin
      dout_ready = (c % 2 == 0);
      chk("t2_valid", dout_valid, 1);
      if (held) chk("t2_hold", dout, held_val);
      if (dout_ready) begin
        got[n] = dout; n++; held = 1'b0;
      end else begin
        held = 1'b1; held_val = dout;
      end
      step();
    end
    chk("t2_count", n, 16);
    for (int b = 0; b < 16; b++) chk("t2_byte", got[b], exp0[b]);
    chk("t2_idle", dout_valid, 0);

    // Overflow: five back-to-back blocks with consumer stalled
    dout_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      C_in = mk_blk(k); valid_in = 1'b1;
      step();
      if (k == 2) chk("t3_not_full", full, 0);
      if (k == 3) chk("t3_full", full, 1);
      if (k == 3) chk("t3_no_ovf_yet", overflow, 0);
      if (k == 4) chk("t3_ovf", overflow, 1);
    end
    valid_in = 1'b0; dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 16; b++) begin
        chk("t3_drain", dout, 8'(k*16 + b));
        step();
      end
    end
    chk("t3_drained", dout_valid, 0);
    chk("t3_ovf_sticky", overflow, 1);
    chk("t3_empty_full", full, 0);

    rst = 1'b0;
    #1;
    chk("rst2_ovf_clear", overflow, 0);
    step();
    rst = 1'b1;
    step();

    // Write accepted in the cycle the full FIFO pops its head
    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      C_in = mk_blk(k); valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    chk("t4_full", full, 1);
    dout_ready = 1'b1;
    repeat (15) step();
    chk("t4_byte15", dout, 8'h0f);
    C_in = mk_blk(5); valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("t4_still_full", full, 1);
    chk("t4_no_ovf", overflow, 0);
    order = '{1, 2, 3, 5};
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 16; b++) begin
        chk("t4_drain", dout, 8'(order[i]*16 + b));
        step();
      end
    end
    chk("t4_idle", dout_valid, 0);

    // Reset in the middle of a block
    dout_ready = 1'b0;
    for (int k = 6; k < 10; k++) begin
      C_in = mk_blk(k); valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    chk("t5_full", full, 1);
    dout_ready = 1'b1;
    repeat (8) step();
    chk("t5_byte8", dout, 8'h68);
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", dout_valid, 0);
    chk("t5_rst_full", full, 0);
    chk("t5_rst_dout", dout, 8'h00);
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_quiet", dout_valid, 0);
    end
    C_in = mk_blk(10); valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("t5_new_valid", dout_valid, 1);
    chk("t5_new_byte0", dout, 8'ha0);
    repeat (16) step();
    chk("t5_idle", dout_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, setting the ciphertext FIFO depth in 128-bit entries; legal values are 2, 4, 8 and 16.
REQ-002 SHALL have input clk, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have input rst, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input C_in, 128 bits: ciphertext block from the AES pipeline output C.
REQ-005 SHALL have input valid_in, 1 bit: C_in is valid this cycle; driven by the AES pipeline valid.
REQ-006 SHALL have output dout, 8 bits: the current ciphertext byte.
REQ-007 SHALL have output dout_valid, 1 bit: dout holds a byte.
REQ-008 SHALL have input dout_ready, 1 bit: the consumer accepts dout this cycle.
REQ-009 SHALL have output full, 1 bit: the FIFO holds DEPTH entries.
REQ-010 SHALL have output overflow, 1 bit: sticky flag; a block was dropped.

Function
REQ-011 SHALL store C_in into the FIFO tail on a rising edge where valid_in=1 and a slot is free.
REQ-012 SHALL free a slot for REQ-011 when count<DEPTH, or when count=DEPTH and the last byte of the head entry is transferred in the same cycle.
REQ-013 SHALL drop C_in and set overflow=1 when valid_in=1 and no slot is free; the stored entries and pointers are left unchanged.
REQ-014 SHALL keep overflow at 1 until reset; no other event clears it.
REQ-015 SHALL run a two-state FSM: IDLE (count=0) and SEND (count>0).
- IDLE->SEND on any accepted write.
- SEND->IDLE when the last byte of the only entry transfers and no write occurs in that cycle.
REQ-016 SHALL drive dout_valid=1 exactly in SEND, so the first byte is presented the cycle after the accepting valid_in edge (1-cycle latency).
REQ-017 SHALL present head-entry bytes MSB first: byte index b (0..15) drives dout=head[127-8b:120-8b].
REQ-018 SHALL count a transfer when dout_valid=1 and dout_ready=1.
- Each transfer advances a 4-bit byte counter.
- At b=15 the counter wraps to 0 and the head entry is popped.
REQ-019 SHALL hold dout and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-020 SHALL ignore dout_ready in IDLE.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH; count is log2(DEPTH)+1 bits wide.
REQ-022 SHALL apply a simultaneous write and pop as count unchanged, with both pointers advanced.
REQ-023 SHALL drive full=1 exactly when count=DEPTH, registered (no combinational path from inputs).
REQ-024 SHALL accept one valid_in per cycle, so back-to-back blocks from the pipeline are absorbed until full.

Reset
REQ-025 SHALL, while rst=0, asynchronously force:
- FSM=IDLE, count=0, pointers=0, byte counter=0;
- dout=8'h00, dout_valid=0, full=0, overflow=0.
REQ-026 SHALL, on reset mid-transfer, discard all stored entries; after rst deasserts, no byte is output until a new valid_in.
REQ-027 SHALL NOT reset the FIFO storage array.

Configuration
REQ-028 SHALL, when macro AES_OUT_PARITY_EN is defined, add output dout_par (1 bit).
- dout_par is even parity of dout (XOR of its 8 bits), valid with dout_valid.
- dout_par resets to 0.
REQ-029 SHALL, when AES_OUT_PARITY_EN is undefined, have no dout_par port and no parity logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover single block: valid_in pulse with C_in=128'h69c4e0d86a7b0430d8cdb78070b4c55a, dout_ready=1 -> dout_valid rises next cycle, bytes 69,c4,e0,...,c5,5a over 16 cycles, then IDLE.
REQ-031 SHALL cover backpressure: the same block with dout_ready toggled 1,0,1,0 -> each byte held while ready=0, 16 distinct bytes in order, none duplicated or lost.
REQ-032 SHALL cover overflow: DEPTH=4, dout_ready=0, 5 consecutive valid_in -> full=1 after the 4th, overflow=1 after the 5th; draining yields exactly 4 blocks (64 bytes); overflow remains 1.
REQ-033 SHALL cover simultaneous write at full: count=4, valid_in asserted in the cycle byte 15 of the head transfers -> write accepted, count stays 4, overflow stays 0.
REQ-034 SHALL cover reset mid-operation: rst=0 asserted after byte 7 of a block -> dout_valid=0 and full=0 immediately; after release, dout_valid=0 until a new valid_in.
REQ-035 SHALL cover parity: with AES_OUT_PARITY_EN defined, byte 8'h69 -> dout_par=0 and byte 8'hc4 -> dout_par=1.
